// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed hex display driver with double-buffered value and frame-wrap update.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = 6 * NUM_DIGITS;
  localparam logic SEG_OFF = SEG_ACTIVE_LOW != 0;
  localparam logic AN_OFF = AN_ACTIVE_LOW != 0;
  localparam logic [6:0] CODES [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [BW-1:0] shadow, disp, incoming;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0] disp_dp, disp_en, an_sel;
  logic cnt_wrap, frame_wrap, lit_phase, cur_dp, cur_en, supp, zeros, digit_on, selected, dp_lit;
  logic [3:0] nib;
  logic [6:0] seg_lit;
  assign incoming = {value_in, dp_in, digit_en};
  assign {disp_val, disp_dp, disp_en} = disp;
  assign cnt_wrap = cnt == CW'(SCAN_DIV - 1);
  assign frame_wrap = cnt_wrap && idx == IW'(NUM_DIGITS - 1);
  assign lit_phase = cnt >= CW'(BLANK_CYCLES);
  // Walk from the top digit down so zeros covers nibbles N-1..i when i is reached.
  always_comb begin
    nib = '0;
    cur_dp = 1'b0;
    cur_en = 1'b0;
    supp = 1'b0;
    zeros = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeros = zeros && disp_val[4*i +: 4] == 4'h0;
      if (idx == IW'(i)) begin
        nib = disp_val[4*i +: 4];
        cur_dp = disp_dp[i];
        cur_en = disp_en[i];
        supp = lz_blank && zeros && i != 0;
      end
    end
  end
  // A suppressed leading zero still selects its anode when its decimal point must light.
  assign digit_on = lit_phase && cur_en && !supp;
  assign selected = lit_phase && cur_en && (!supp || cur_dp);
  assign seg_lit = digit_on ? CODES[nib] : 7'h00;
  assign dp_lit = selected && cur_dp;
  assign an_sel = selected ? NUM_DIGITS'(1) << idx : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      shadow <= '0;
      disp <= '0;
      frame_done <= 1'b0;
      seg <= {7{SEG_OFF}};
      dp <= SEG_OFF;
      an <= {NUM_DIGITS{AN_OFF}};
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
      if (load) shadow <= incoming;
      if (frame_wrap) disp <= load ? incoming : shadow;
      frame_done <= frame_wrap;
      seg <= seg_lit ^ {7{SEG_OFF}};
      dp <= dp_lit ^ SEG_OFF;
      an <= an_sel ^ {NUM_DIGITS{AN_OFF}};
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed frame-by-frame checks of scan order, buffering, blanking and reset.
module tb_seven_seg_scan_driver;
  logic clk = 1'b0;
  logic rst_n, load, lz_blank, dp, frame_done;
  logic [15:0] value_in;
  logic [3:0] dp_in, digit_en, an;
  logic [6:0] seg;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  seven_seg_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(1),
                          .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in),
    .digit_en(digit_en), .lz_blank(lz_blank), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_off(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_an"}, 32'(an), 32'hF);
  endtask
  // Entered on the sample where frame_done is seen (cnt=0, idx=0 just loaded); leaves on the next one.
  task automatic frame(input string tag, input logic [15:0] an_e, input logic [27:0] seg_e,
                       input logic [3:0] dp_e, input int ld_at, input logic [15:0] lv,
                       input logic [3:0] ldp, input logic [3:0] len);
    int d, c;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (j == ld_at) begin
        load = 1'b1;
        value_in = lv;
        dp_in = ldp;
        digit_en = len;
      end else load = 1'b0;
      d = (j - 1) / 4;
      c = (j - 1) % 4;
      if (c == 0) chk_off({tag, "_guard"});
      else begin
        chk({tag, "_an"}, 32'(an), 32'(an_e[4*d +: 4]));
        chk({tag, "_seg"}, 32'(seg), 32'(seg_e[7*d +: 7]));
        chk({tag, "_dp"}, 32'(dp), 32'(dp_e[d]));
      end
      if (j == 8) chk({tag, "_fd_mid"}, 32'(frame_done), 32'h0);
    end
    chk({tag, "_fd_end"}, 32'(frame_done), 32'h1);
  endtask
  initial begin
    rst_n = 1'b0;
    load = 1'b0;
    lz_blank = 1'b0;
    value_in = '0;
    dp_in = '0;
    digit_en = '0;
    repeat (3) @(negedge clk);
    chk_off("reset");
    chk("reset_fd", 32'(frame_done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    load = 1'b1;
    value_in = 16'h1234;
    dp_in = 4'h0;
    digit_en = 4'hF;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 64 && !frame_done; k++) @(negedge clk);
    chk("first_fd", 32'(frame_done), 32'h1);
    frame("f1234", 16'h7BDE, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'hF, 5, 16'hABCD, 4'h0, 4'hF);
    frame("fABCD", 16'h7BDE, {7'h08, 7'h60, 7'h31, 7'h42}, 4'hF, 15, 16'h0050, 4'h0, 4'hF);
    lz_blank = 1'b1;
    frame("f0050", 16'hFFDE, {7'h7F, 7'h7F, 7'h24, 7'h01}, 4'hF, 15, 16'h0000, 4'h0, 4'hF);
    frame("f0000", 16'hFFFE, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'hF, 15, 16'h5678, 4'b0100, 4'b1101);
    lz_blank = 1'b0;
    frame("fdpen", 16'h7BFE, {7'h24, 7'h20, 7'h7F, 7'h00}, 4'b1011, 0, 16'h0, 4'h0, 4'h0);
    repeat (10) @(negedge clk);
    chk("pre_rst_an", 32'(an), 32'hB);
    chk("pre_rst_seg", 32'(seg), 32'h20);
    #2 rst_n = 1'b0;
    #1 chk_off("async_rst");
    chk("async_rst_fd", 32'(frame_done), 32'h0);
    repeat (2) @(negedge clk);
    chk_off("held_rst");
    rst_n = 1'b1;
    frame("post_rst", 16'hFFFF, {4{7'h7F}}, 4'hF, 0, 16'h0, 4'h0, 4'h0);
    frame("idle", 16'hFFFF, {4{7'h7F}}, 4'hF, 5, 16'h1234, 4'h0, 4'hF);
    frame("reload", 16'h7BDE, {7'h4F, 7'h12, 7'h06, 7'h4C}, 4'hF, 0, 16'h0, 4'h0, 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
